// File: rtl/cons_dma_bridge_pkg.sv
// Shared definitions for the console DMA bridge: state encoding, I/O-page
// relocation constants and the data returned to the console on a bus timeout.
package cons_dma_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_GNT = 3'd1,
    ST_GRANTED  = 3'd2,
    ST_CYCLE    = 3'd3,
    ST_ACKED    = 3'd4,
    ST_RELEASE  = 3'd5
  } cons_state_e;

  localparam logic [17:0] CONS_IOPAGE_BASE = 18'o760000;
  localparam logic [21:0] SYS_IOPAGE_BASE  = 22'o17760000;
  localparam logic [15:0] TMO_DATA         = 16'o177777;

  // Word-aligned 18 -> 22 bit address; the top 8 KB of console space lands in the I/O page.
  function automatic logic [21:0] cons_map_adr(input logic [17:0] adr, input bit iopage_map);
    logic [21:0] a;
    a = {4'b0000, adr[17:1], 1'b0};
    if (iopage_map && (adr[17:13] == CONS_IOPAGE_BASE[17:13]))
      a[21:18] = SYS_IOPAGE_BASE[21:18];
    return a;
  endfunction

endpackage

// File: rtl/cons_bus_timer.sv
// Bus-cycle watchdog: counts while enabled, clears on demand, and flags
// the terminal count TMO_CYCLES-1 (saturating there).
module cons_bus_timer #(
  parameter int TMO_CYCLES = 64
) (
  input  logic clk_p,
  input  logic sys_init,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int W = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk_p) begin
    if (sys_init || clr)
      cnt <= '0;
    else if (en && !term)
      cnt <= cnt + W'(1);
  end

  assign term = (cnt == W'(TMO_CYCLES - 1));

endmodule

// File: rtl/cons_dma_bridge.sv
// Front-panel console DMA master bridged onto the 22-bit Wishbone bus.
// Handshake: console holds stb until ack, bridge holds ack until stb drops.
module cons_dma_bridge
  import cons_dma_bridge_pkg::*;
#(
  parameter int TMO_CYCLES = 64,
  parameter bit IOPAGE_MAP = 1'b1
) (
  input  logic        clk_p,
  input  logic        sys_init,
  input  logic        c_dma_req,
  output logic        c_dma_gnt,
  input  logic [17:0] c_dma_adr_i,
  input  logic [15:0] c_dma_dat_i,
  input  logic        c_dma_stb_i,
  input  logic        c_dma_we_i,
  output logic [15:0] c_dma_dat_o,
  output logic        c_dma_ack_o,
  output logic        cpu_dma_req,
  input  logic        cpu_dma_gnt,
  output logic [21:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i,
  output logic        bus_tmo,
  output logic [21:0] tmo_adr
);

  cons_state_e state_q, state_d;
  logic        tmr_term;
  logic        cpu_req_d, gnt_d, cyc_d, we_d, ack_d, tmo_d;
  logic [21:0] adr_d, tmo_adr_d;
  logic [15:0] wdat_d, rdat_d;

  cons_bus_timer #(.TMO_CYCLES(TMO_CYCLES)) u_timer (
    .clk_p    (clk_p),
    .sys_init (sys_init),
    .clr      (state_q != ST_CYCLE),
    .en       (state_q == ST_CYCLE),
    .term     (tmr_term)
  );

  always_ff @(posedge clk_p) begin
    if (sys_init) begin
      state_q     <= ST_IDLE;
      cpu_dma_req <= 1'b0;
      c_dma_gnt   <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      c_dma_dat_o <= '0;
      c_dma_ack_o <= 1'b0;
      bus_tmo     <= 1'b0;
      tmo_adr     <= '0;
    end else begin
      state_q     <= state_d;
      cpu_dma_req <= cpu_req_d;
      c_dma_gnt   <= gnt_d;
      wb_cyc_o    <= cyc_d;
      wb_stb_o    <= cyc_d;
      wb_we_o     <= we_d;
      wb_adr_o    <= adr_d;
      wb_dat_o    <= wdat_d;
      c_dma_dat_o <= rdat_d;
      c_dma_ack_o <= ack_d;
      bus_tmo     <= tmo_d;
      tmo_adr     <= tmo_adr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (c_dma_req) state_d = ST_WAIT_GNT;
      ST_WAIT_GNT: if (!c_dma_req) state_d = ST_IDLE;
                   else if (cpu_dma_gnt) state_d = ST_GRANTED;
      ST_GRANTED:  if (c_dma_stb_i) state_d = ST_CYCLE;
                   else if (!c_dma_req) state_d = ST_RELEASE;
      ST_CYCLE:    if (wb_ack_i || tmr_term) state_d = ST_ACKED;
      ST_ACKED:    if (!c_dma_stb_i) state_d = c_dma_req ? ST_GRANTED : ST_RELEASE;
      ST_RELEASE:  if (!cpu_dma_gnt) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // A falling cpu_dma_gnt while granted is deliberately ignored until RELEASE.
  always_comb begin
    cpu_req_d = cpu_dma_req;
    gnt_d     = c_dma_gnt;
    cyc_d     = wb_cyc_o;
    we_d      = wb_we_o;
    adr_d     = wb_adr_o;
    wdat_d    = wb_dat_o;
    rdat_d    = c_dma_dat_o;
    ack_d     = c_dma_ack_o;
    tmo_d     = bus_tmo;
    tmo_adr_d = tmo_adr;
    case (state_q)
      ST_IDLE:     if (c_dma_req) cpu_req_d = 1'b1;
      ST_WAIT_GNT: if (!c_dma_req) cpu_req_d = 1'b0;
                   else if (cpu_dma_gnt) gnt_d = 1'b1;
      ST_GRANTED: begin
        if (c_dma_stb_i) begin
          adr_d  = cons_map_adr(c_dma_adr_i, IOPAGE_MAP);
          wdat_d = c_dma_dat_i;
          we_d   = c_dma_we_i;
          cyc_d  = 1'b1;
          tmo_d  = 1'b0;
        end else if (!c_dma_req) begin
          gnt_d     = 1'b0;
          cpu_req_d = 1'b0;
        end
      end
      ST_CYCLE: begin
        if (wb_ack_i) begin
          cyc_d  = 1'b0;
          ack_d  = 1'b1;
          rdat_d = wb_we_o ? wb_dat_o : wb_dat_i;
        end else if (tmr_term) begin
          cyc_d     = 1'b0;
          ack_d     = 1'b1;
          rdat_d    = TMO_DATA;
          tmo_d     = 1'b1;
          tmo_adr_d = wb_adr_o;
        end
      end
      ST_ACKED: begin
        if (!c_dma_stb_i) begin
          ack_d = 1'b0;
          if (!c_dma_req) begin
            gnt_d     = 1'b0;
            cpu_req_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign wb_sel_o = 2'b11;

endmodule

// File: doc/cons_dma_bridge.md
Name: cons_dma_bridge

Overview:
- Bridges the front-panel console's DMA master port onto the 22-bit system Wishbone bus.
- Console-side exchange: req/gnt/stb/ack. The block forwards the request to the CPU, waits for the CPU to release the bus, runs one word cycle per console strobe, and maps the 18-bit console address to 22 bits (I/O-page relocation).
- A bus timeout guarantees the console never hangs on a non-existent address; the timeout is reported for the panel ADDR ERR lamp.

Parameters:
- TMO_CYCLES, 64, clk_p cycles without wb_ack_i before a cycle is aborted (min 2).
- IOPAGE_MAP, 1, when 1, console addresses 760000-777777 (18-bit octal) map to 17760000-17777777 (22-bit octal).

Ports:
- clk_p  in  1  system clock, all logic on rising edge.
- sys_init  in  1  reset, synchronous, active-high.
- c_dma_req  in  1  console bus request.
- c_dma_gnt  out  1  grant to console.
- c_dma_adr_i  in  18  console address.
- c_dma_dat_i  in  16  console write data.
- c_dma_stb_i  in  1  console cycle strobe.
- c_dma_we_i  in  1  1 = write (deposit), 0 = read (examine).
- c_dma_dat_o  out  16  read data to console.
- c_dma_ack_o  out  1  cycle done to console.
- cpu_dma_req  out  1  bus request to CPU.
- cpu_dma_gnt  in  1  CPU bus released.
- wb_adr_o  out  22  bus address, bit0 always 0.
- wb_dat_o  out  16  bus write data.
- wb_dat_i  in  16  bus read data.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  bus strobe.
- wb_we_o  out  1  bus write.
- wb_sel_o  out  2  byte lanes, constant 2'b11.
- wb_ack_i  in  1  bus acknowledge.
- bus_tmo  out  1  last cycle timed out (sticky).
- tmo_adr  out  22  address of the timed-out cycle.

Behaviour:
- Reset (sys_init=1 at a clock edge):
  - All outputs 0 (wb_sel_o=2'b11); state IDLE; timer 0.
  - Reset mid-cycle drops wb_cyc_o, wb_stb_o and c_dma_gnt on that edge, with no ack to the console.
- All outputs are registered. States:
  - IDLE: c_dma_req=1 -> cpu_dma_req<=1, go WAIT_GNT.
  - WAIT_GNT: c_dma_req=0 -> cpu_dma_req<=0, go IDLE. Else cpu_dma_gnt=1 -> c_dma_gnt<=1, go GRANTED.
  - GRANTED:
    - c_dma_stb_i=1 -> latch address, data and we. Drive wb_adr_o/wb_dat_o/wb_we_o; wb_cyc_o=wb_stb_o<=1; timer<=0; bus_tmo<=0; go CYCLE.
    - Else c_dma_req=0 -> c_dma_gnt<=0, cpu_dma_req<=0, go RELEASE.
  - CYCLE: timer increments each cycle.
    - wb_ack_i=1 -> c_dma_dat_o<=wb_dat_i (on read; on write it holds c_dma_dat_i), cyc/stb<=0, c_dma_ack_o<=1, go ACKED.
    - Else timer==TMO_CYCLES-1 -> cyc/stb<=0, c_dma_dat_o<=16'o177777, bus_tmo<=1, tmo_adr<=wb_adr_o, c_dma_ack_o<=1, go ACKED.
    - Ack and timeout on the same edge: ack wins, no timeout flagged.
  - ACKED: c_dma_ack_o held while c_dma_stb_i=1. When c_dma_stb_i=0:
    - c_dma_ack_o<=0.
    - If c_dma_req=0 (console drops stb and req together): c_dma_gnt<=0, cpu_dma_req<=0, go RELEASE.
    - Else go GRANTED.
  - RELEASE: wait cpu_dma_gnt=0 -> IDLE. A new c_dma_req is not accepted until IDLE.
- Address mapping:
  - wb_adr_o = {4'b0, c_dma_adr_i[17:1], 1'b0}.
  - If IOPAGE_MAP and c_dma_adr_i[17:13]=5'b11111, bits [21:18]=4'b1111.
- Latency: GRANTED strobe edge -> wb_stb_o high next edge. wb_ack_i edge -> c_dma_ack_o high next edge.
- c_dma_gnt never drops while wb_cyc_o=1.
- cpu_dma_gnt falling while granted is a protocol violation. The bridge completes the current cycle and ignores the violation (assertion in bench).

Decomposition:
- Shared console package: state encoding localparams (IDLE, WAIT_GNT, GRANTED, CYCLE, ACKED, RELEASE), IOPAGE constants (18'o760000, 22'o17760000), all-ones timeout data 16'o177777.
- One natural sub-module: cons_bus_timer, a clear/enable counter with terminal flag at TMO_CYCLES-1.

Test Plan:
- Examine:
  - Stimulus: req, gnt after 3 cycles, stb with adr 18'o001000 read; slave acks after 2 cycles with 16'o012737.
  - Required: wb_adr_o=22'o00001000, c_dma_dat_o=16'o012737, c_dma_ack_o one cycle after wb_ack_i, bus_tmo=0.
- Deposit:
  - Stimulus: adr 18'o777570 write with 16'o000123 (IOPAGE_MAP=1).
  - Required: wb_adr_o=22'o17777570, wb_we_o=1, wb_dat_o=16'o000123, wb_sel_o=2'b11.
- Timeout:
  - Stimulus: read 18'o600000 with no slave.
  - Required: ack at cycle 64 after stb, c_dma_dat_o=16'o177777, bus_tmo=1, tmo_adr=22'o00600000. A following good cycle clears bus_tmo.
- Simultaneous ack and timeout on the last timer cycle -> normal data returned, bus_tmo=0.
- Release:
  - Stimulus: console drops stb and req together after ack.
  - Required: c_dma_gnt and cpu_dma_req low next edge; state IDLE once cpu_dma_gnt=0. A req raised in RELEASE is not granted until then.
- Reset mid-cycle: sys_init during CYCLE -> wb_cyc_o/wb_stb_o/c_dma_gnt/cpu_dma_req=0 next edge, no c_dma_ack_o pulse; a new req works normally afterward.
